// File: rtl/fcl_pkg.sv
// Shared types and default sizing for the fully-connected-layer MAC controller.
//   fcl_state_e        : controller FSM encoding
//   FCL_OPERAND_WIDTH  : default unsigned operand width
//   FCL_VEC_LEN        : default maximum products per dot product
package fcl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fcl_state_e;

   localparam int FCL_OPERAND_WIDTH = 8;
   localparam int FCL_VEC_LEN       = 16;

endpackage

// File: rtl/mult2.sv
// Registered unsigned multiplier, one cycle of latency.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   a, b  : unsigned operands
//   p     : registered product a*b
module mult2 #(
   parameter int OPERAND_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [OPERAND_WIDTH-1:0]     a,
   input  logic [OPERAND_WIDTH-1:0]     b,
   output logic [2*OPERAND_WIDTH-1:0]   p
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) p <= '0;
      else        p <= a * b;
   end

endmodule

// File: rtl/fcl_mac_ctrl.sv
// Sequencing controller for the FCL shared multiplier: takes a start with a
// run-time length, streams operand pairs over valid/ready into mult2,
// accumulates the products and offers the dot product on a valid/ready port.
//   fcl_mac_ctrl_clk / _rst_b      : clock, async active-low reset
//   fcl_mac_ctrl_start_i / _len_i  : start pulse and vector length (IDLE only)
//   fcl_mac_ctrl_clr_i             : synchronous abort
//   fcl_mac_ctrl_op_valid_i/_ready_o, _a_i, _b_i : operand stream
//   fcl_mac_ctrl_res_valid_o/_ready_i, _res_o    : result port
//   fcl_mac_ctrl_busy_o            : high outside IDLE
//
// state    | meaning
// ST_IDLE  | waiting for start; result port holds last value
// ST_FEED  | accepting operand beats until len beats taken
// ST_DRAIN | one cycle to fold in the last product
// ST_DONE  | result valid, waiting for downstream ready
module fcl_mac_ctrl
   import fcl_pkg::*;
#(
   parameter int OPERAND_WIDTH = FCL_OPERAND_WIDTH,
   parameter int VEC_LEN       = FCL_VEC_LEN,
   parameter int LEN_WIDTH     = $clog2(VEC_LEN+1),
   parameter int ACC_WIDTH     = 2*OPERAND_WIDTH + $clog2(VEC_LEN)
) (
   input  logic                       fcl_mac_ctrl_clk,
   input  logic                       fcl_mac_ctrl_rst_b,
   input  logic                       fcl_mac_ctrl_start_i,
   input  logic [LEN_WIDTH-1:0]       fcl_mac_ctrl_len_i,
   input  logic                       fcl_mac_ctrl_clr_i,
   input  logic                       fcl_mac_ctrl_op_valid_i,
   output logic                       fcl_mac_ctrl_op_ready_o,
   input  logic [OPERAND_WIDTH-1:0]   fcl_mac_ctrl_a_i,
   input  logic [OPERAND_WIDTH-1:0]   fcl_mac_ctrl_b_i,
   output logic                       fcl_mac_ctrl_res_valid_o,
   input  logic                       fcl_mac_ctrl_res_ready_i,
   output logic [ACC_WIDTH-1:0]       fcl_mac_ctrl_res_o,
   output logic                       fcl_mac_ctrl_busy_o
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(VEC_LEN);

   fcl_state_e                   state_q, state_d;
   logic [LEN_WIDTH-1:0]         cnt_q;
   logic [LEN_WIDTH-1:0]         len_q;
   logic [LEN_WIDTH-1:0]         len_clamp;
   logic [ACC_WIDTH-1:0]         acc_q;
   logic [ACC_WIDTH-1:0]         acc_next;
   logic [ACC_WIDTH-1:0]         res_q;
   logic                         prod_vld_q;
   logic                         beat;
   logic [OPERAND_WIDTH-1:0]     mul_a, mul_b;
   logic [2*OPERAND_WIDTH-1:0]   prod;

   assign len_clamp = (fcl_mac_ctrl_len_i > MAX_LEN) ? MAX_LEN : fcl_mac_ctrl_len_i;

   // Inputs held at zero between beats so the multiplier does not toggle.
   assign mul_a = beat ? fcl_mac_ctrl_a_i : '0;
   assign mul_b = beat ? fcl_mac_ctrl_b_i : '0;

   mult2 #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_mult2 (
      .clk   (fcl_mac_ctrl_clk),
      .rst_n (fcl_mac_ctrl_rst_b),
      .a     (mul_a),
      .b     (mul_b),
      .p     (prod)
   );

   assign acc_next = acc_q + (prod_vld_q ? ACC_WIDTH'(prod) : '0);

   always_ff @(posedge fcl_mac_ctrl_clk or negedge fcl_mac_ctrl_rst_b) begin
      if (!fcl_mac_ctrl_rst_b) state_q <= ST_IDLE;
      else                     state_q <= state_d;
   end

   always_comb begin
      state_d                  = state_q;
      beat                     = 1'b0;
      fcl_mac_ctrl_op_ready_o  = 1'b0;
      fcl_mac_ctrl_res_valid_o = 1'b0;
      fcl_mac_ctrl_busy_o      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            fcl_mac_ctrl_busy_o = 1'b0;
            if (fcl_mac_ctrl_start_i)
               state_d = (len_clamp == '0) ? ST_DONE : ST_FEED;
         end
         ST_FEED: begin
            fcl_mac_ctrl_op_ready_o = 1'b1;
            beat = fcl_mac_ctrl_op_valid_i;
            if (beat && (cnt_q + 1'b1 == len_q))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE: begin
            fcl_mac_ctrl_res_valid_o = 1'b1;
            if (fcl_mac_ctrl_res_ready_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (fcl_mac_ctrl_clr_i)
         state_d = ST_IDLE;
   end

   always_ff @(posedge fcl_mac_ctrl_clk or negedge fcl_mac_ctrl_rst_b) begin
      if (!fcl_mac_ctrl_rst_b) begin
         cnt_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         res_q      <= '0;
         prod_vld_q <= 1'b0;
      end else if (fcl_mac_ctrl_clr_i) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         prod_vld_q <= 1'b0;
      end else begin
         prod_vld_q <= beat;
         if (state_q == ST_IDLE && fcl_mac_ctrl_start_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            len_q <= len_clamp;
            res_q <= '0;
         end else begin
            if (beat) cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_next;
            // Result register only loads the completed sum, never a partial one.
            if (state_q == ST_DRAIN) res_q <= acc_next;
         end
      end
   end

   assign fcl_mac_ctrl_res_o = res_q;

endmodule
